// File: rtl/matrix_entry_buffer.sv
// Parametrised DIM x DIM matrix entry store with address/cursor writes, fill tracking and a
// lock/unlock handshake that freezes the packed matrix while the determinant engine loads it.
// Optional feature macro: MATRIX_BUF_SNAPSHOT_EN (shadow copy taken on lock; live array stays
// writable while locked).
module matrix_entry_buffer #(
  parameter int unsigned DIM    = 8,
  parameter int unsigned ELEM_W = 4,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned CNT_W  = 7
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      Clear,
  input  logic                      Enter,
  input  logic                      AutoInc,
  input  logic [IDX_W-1:0]          Row,
  input  logic [IDX_W-1:0]          Col,
  input  logic [ELEM_W-1:0]         Din,
  input  logic                      Lock,
  input  logic                      Unlock,
  output logic                      Locked,
  output logic                      Ready,
  output logic [IDX_W-1:0]          Cur_row,
  output logic [IDX_W-1:0]          Cur_col,
  output logic [ELEM_W-1:0]         Rd_data,
  output logic [DIM*DIM*ELEM_W-1:0] Matrix_flat,
  output logic [CNT_W-1:0]          Fill_count,
  output logic                      Full,
  output logic                      Err
);

  localparam int unsigned NumElem = DIM * DIM;
  localparam int unsigned FlatW   = NumElem * ELEM_W;

  typedef enum logic [0:0] {StEntry, StLocked} state_e;

  state_e              state_q, state_d;
  logic [FlatW-1:0]    mem_q, mem_d;
  logic [NumElem-1:0]  bitmap_q, bitmap_d;
  logic [IDX_W-1:0]    cur_row_q, cur_row_d;
  logic [IDX_W-1:0]    cur_col_q, cur_col_d;
  logic [ELEM_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    act_row, act_col;
  logic                in_range;
  int unsigned         act_idx;
  logic [ELEM_W-1:0]   rd_elem;
  logic                was_set;
  logic                entry_open;
  logic                clear_ok;
  logic                wr_ok;
  logic                err_set;

  // Address decode, request qualification and read of the element at the active address
  always_comb begin
    act_row  = AutoInc ? cur_row_q : Row;
    act_col  = AutoInc ? cur_col_q : Col;
    in_range = (32'(act_row) < DIM) && (32'(act_col) < DIM);
    act_idx  = 32'(act_row) * DIM + 32'(act_col);
    rd_elem  = '0;
    was_set  = 1'b0;
    for (int unsigned i = 0; i < NumElem; i++) begin
      if (in_range && (i == act_idx)) begin
        rd_elem = mem_q[i*ELEM_W +: ELEM_W];
        was_set = bitmap_q[i];
      end
    end
`ifdef MATRIX_BUF_SNAPSHOT_EN
    entry_open = 1'b1;
`else
    entry_open = (state_q == StEntry);
`endif
    clear_ok = Clear && entry_open;
    // Clear wins over a same-cycle Enter, which is then silently discarded
    wr_ok    = Enter && entry_open && in_range && !clear_ok;
    err_set  = (Clear && !entry_open) ||
               (Enter && !clear_ok && (!entry_open || !in_range));
  end

  // Lock handshake: each state leaves on its own request, so Lock+Unlock together toggles
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEntry:  if (Lock)   state_d = StLocked;
      StLocked: if (Unlock) state_d = StEntry;
      default:  state_d = StEntry;
    endcase
  end

  // Next-state of the array, bitmap, fill counter, cursor, read register and error flag
  always_comb begin
    mem_d     = mem_q;
    bitmap_d  = bitmap_q;
    fill_d    = fill_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    err_d     = err_q | err_set;
    rd_d      = '0;

    if (clear_ok) begin
      mem_d     = '0;
      bitmap_d  = '0;
      fill_d    = '0;
      cur_row_d = '0;
      cur_col_d = '0;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < NumElem; i++) begin
        if (i == act_idx) begin
          mem_d[i*ELEM_W +: ELEM_W] = Din;
          bitmap_d[i]               = 1'b1;
        end
      end
      if (!was_set) fill_d = fill_q + 1'b1;
      if (AutoInc) begin
        if (cur_col_q == IDX_W'(DIM - 1)) begin
          cur_col_d = '0;
          cur_row_d = (cur_row_q == IDX_W'(DIM - 1)) ? '0 : cur_row_q + 1'b1;
        end else begin
          cur_col_d = cur_col_q + 1'b1;
        end
      end
    end

    // Read bypasses a same-cycle write so Rd_data never shows stale data
    if (clear_ok || !in_range) rd_d = '0;
    else if (wr_ok)            rd_d = Din;
    else                       rd_d = rd_elem;
  end

  // State registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StEntry;
      mem_q     <= '0;
      bitmap_q  <= '0;
      fill_q    <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      bitmap_q  <= bitmap_d;
      fill_q    <= fill_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
    end
  end

`ifdef MATRIX_BUF_SNAPSHOT_EN
  logic [FlatW-1:0] shadow_q, shadow_d;

  // Capture the pre-write array on the lock edge so the engine sees a stable copy
  always_comb begin
    shadow_d = shadow_q;
    if ((state_q == StEntry) && Lock) shadow_d = mem_q;
  end

  // Shadow register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) shadow_q <= '0;
    else          shadow_q <= shadow_d;
  end

  assign Matrix_flat = (state_q == StLocked) ? shadow_q : mem_q;
  assign Ready       = 1'b1;
`else
  assign Matrix_flat = mem_q;
  assign Ready       = (state_q == StEntry);
`endif

  assign Locked     = (state_q == StLocked);
  assign Cur_row    = cur_row_q;
  assign Cur_col    = cur_col_q;
  assign Rd_data    = rd_q;
  assign Fill_count = fill_q;
  assign Full       = (fill_q == CNT_W'(NumElem));
  assign Err        = err_q;

endmodule

// File: tb/tb_matrix_entry_buffer.sv
// Directed bench for matrix_entry_buffer at DIM=3 (IDX_W=2 so row/col 3 is out of range).
module tb_matrix_entry_buffer;

  localparam int unsigned DIM    = 3;
  localparam int unsigned ELEM_W = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FlatW  = DIM * DIM * ELEM_W;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Clear = 1'b0, Enter = 1'b0, AutoInc = 1'b0;
  logic [IDX_W-1:0]  Row = '0, Col = '0;
  logic [ELEM_W-1:0] Din = '0;
  logic              Lock = 1'b0, Unlock = 1'b0;
  logic              Locked, Ready, Full, Err;
  logic [IDX_W-1:0]  Cur_row, Cur_col;
  logic [ELEM_W-1:0] Rd_data;
  logic [FlatW-1:0]  Matrix_flat;
  logic [CNT_W-1:0]  Fill_count;

  int total = 0;
  int bad   = 0;

  matrix_entry_buffer #(
    .DIM(DIM), .ELEM_W(ELEM_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .Enter(Enter), .AutoInc(AutoInc),
    .Row(Row), .Col(Col), .Din(Din), .Lock(Lock), .Unlock(Unlock),
    .Locked(Locked), .Ready(Ready), .Cur_row(Cur_row), .Cur_col(Cur_col),
    .Rd_data(Rd_data), .Matrix_flat(Matrix_flat), .Fill_count(Fill_count),
    .Full(Full), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_locked"}, 64'(Locked), 64'd0);
    check({tag, "_ready"}, 64'(Ready), 64'd1);
    check({tag, "_rd"}, 64'(Rd_data), 64'd0);
    check({tag, "_fill"}, 64'(Fill_count), 64'd0);
    check({tag, "_full"}, 64'(Full), 64'd0);
    check({tag, "_err"}, 64'(Err), 64'd0);
    check({tag, "_flat"}, 64'(Matrix_flat), 64'd0);
    check({tag, "_cur"}, 64'({Cur_row, Cur_col}), 64'd0);
  endtask

  initial begin
    // Reset
    #3;
    check_reset_vals("rst");
    #4 Reset_n = 1'b1;
    tick();

    // Manual write (1,2)=A lands at bits [23:20]
    Row = 2'd1; Col = 2'd2; Din = 4'hA; Enter = 1'b1;
    tick();
    Enter = 1'b0;
    check("t1_elem", 64'(Matrix_flat[23:20]), 64'hA);
    check("t1_flat", 64'(Matrix_flat), 64'h000A00000);
    check("t1_fill", 64'(Fill_count), 64'd1);
    check("t1_rd", 64'(Rd_data), 64'hA);
    check("t1_cur", 64'({Cur_row, Cur_col}), 64'd0);

    // Clear, then 10 auto-increment writes 1..10
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("t2_clr_flat", 64'(Matrix_flat), 64'd0);
    check("t2_clr_fill", 64'(Fill_count), 64'd0);
    AutoInc = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      Din = 4'(i); Enter = 1'b1;
      tick();
      if (i == 9) begin
        check("t2_full9", 64'(Full), 64'd1);
        check("t2_wrap", 64'({Cur_row, Cur_col}), 64'd0);
      end
    end
    Enter = 1'b0;
    check("t2_flat", 64'(Matrix_flat), 64'h98765432A);
    check("t2_cur", 64'({Cur_row, Cur_col}), 64'h1);
    check("t2_full", 64'(Full), 64'd1);
    check("t2_fill", 64'(Fill_count), 64'd9);
    check("t2_rd_bypass", 64'(Rd_data), 64'hA);
    tick();
    check("t2_rd_cursor", 64'(Rd_data), 64'h2);
    AutoInc = 1'b0;

`ifdef MATRIX_BUF_SNAPSHOT_EN
    // Snapshot: locked view frozen, live array keeps accepting writes
    Row = 2'd0; Col = 2'd0; Din = 4'h5; Enter = 1'b1;
    tick();
    Enter = 1'b0; Lock = 1'b1;
    tick();
    Lock = 1'b0;
    check("t5_locked", 64'(Locked), 64'd1);
    check("t5_ready", 64'(Ready), 64'd1);
    Din = 4'h7; Enter = 1'b1;
    tick();
    Enter = 1'b0;
    check("t5_shadow", 64'(Matrix_flat[3:0]), 64'h5);
    check("t5_err", 64'(Err), 64'd0);
    Unlock = 1'b1;
    tick();
    Unlock = 1'b0;
    check("t5_live", 64'(Matrix_flat[3:0]), 64'h7);
    check("t5_fill", 64'(Fill_count), 64'd9);
`else
    // Lock, then illegal Enter and Clear while locked
    Lock = 1'b1;
    tick();
    Lock = 1'b0;
    check("t3_locked", 64'(Locked), 64'd1);
    check("t3_ready", 64'(Ready), 64'd0);
    check("t3_err0", 64'(Err), 64'd0);
    Row = 2'd0; Col = 2'd0; Din = 4'hF; Enter = 1'b1; Clear = 1'b1;
    tick();
    Enter = 1'b0; Clear = 1'b0;
    check("t3_frozen", 64'(Matrix_flat), 64'h98765432A);
    check("t3_fill", 64'(Fill_count), 64'd9);
    check("t3_err", 64'(Err), 64'd1);
    Unlock = 1'b1;
    tick();
    Unlock = 1'b0;
    check("t3_unlock_ready", 64'(Ready), 64'd1);
    check("t3_unlock_locked", 64'(Locked), 64'd0);
    check("t3_err_sticky", 64'(Err), 64'd1);
    // Lock and Unlock together toggle out of the current state
    Lock = 1'b1; Unlock = 1'b1;
    tick();
    check("t3_both_entry", 64'(Locked), 64'd1);
    tick();
    check("t3_both_locked", 64'(Locked), 64'd0);
    Lock = 1'b0; Unlock = 1'b0;
`endif

    // Asynchronous reset pulse away from the clock edge
    #2 Reset_n = 1'b0;
    #1;
    check_reset_vals("t6");
    #2 Reset_n = 1'b1;
    tick();
    check("t6_after_edge_ready", 64'(Ready), 64'd1);

    // Out-of-range write, then Clear beating Enter
    Row = 2'd0; Col = 2'd0; Din = 4'h3; Enter = 1'b1;
    tick();
    check("t4_fill1", 64'(Fill_count), 64'd1);
    check("t4_flat1", 64'(Matrix_flat), 64'h3);
    check("t4_cur_manual", 64'({Cur_row, Cur_col}), 64'd0);
    Row = 2'd3; Din = 4'h5;
    tick();
    Enter = 1'b0;
    check("t4_oor_err", 64'(Err), 64'd1);
    check("t4_oor_fill", 64'(Fill_count), 64'd1);
    check("t4_oor_flat", 64'(Matrix_flat), 64'h3);
    check("t4_oor_rd", 64'(Rd_data), 64'd0);
    Row = 2'd1; Col = 2'd1; Din = 4'h7; Enter = 1'b1; Clear = 1'b1;
    tick();
    Enter = 1'b0; Clear = 1'b0;
    check("t4_clr_flat", 64'(Matrix_flat), 64'd0);
    check("t4_clr_fill", 64'(Fill_count), 64'd0);
    check("t4_clr_full", 64'(Full), 64'd0);
    check("t4_err_kept", 64'(Err), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
